// File: rtl/facto_host_master_if.sv
// Command, core bus and response signals between a host controller, facto_host_master and the factorial core.
interface facto_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_operand;
  logic        m_sel;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic [63:0] m_din;
  logic        interrupt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result_h;
  logic [63:0] rsp_result_l;
  logic        rsp_error;

  // View of the bus initiator
  modport master (
    input  cmd_valid, cmd_operand, m_din, interrupt, rsp_ready,
    output cmd_ready, m_sel, m_wr, m_addr, m_dout,
           rsp_valid, rsp_result_h, rsp_result_l, rsp_error
  );

  // View of the surrounding host and core
  modport slave (
    output cmd_valid, cmd_operand, m_din, interrupt, rsp_ready,
    input  cmd_ready, m_sel, m_wr, m_addr, m_dout,
           rsp_valid, rsp_result_h, rsp_result_l, rsp_error
  );
endinterface

// File: rtl/facto_host_master.sv
// Bus initiator: programs the factorial core for one operand, waits for completion, returns the 128-bit result.
module facto_host_master #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter bit          USE_INTR  = 1'b1,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned TIMEOUT   = 4096
) (
  input logic           clk,
  input logic           reset_n,
  facto_host_master_if.master bus
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;
  localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1) + 1;

  localparam logic [ADDR_W-1:0] OFF_START = 16'h0000;
  localparam logic [ADDR_W-1:0] OFF_CLEAR = 16'h0008;
  localparam logic [ADDR_W-1:0] OFF_DONE  = 16'h0010;
  localparam logic [ADDR_W-1:0] OFF_INTEN = 16'h0018;
  localparam logic [ADDR_W-1:0] OFF_OPND  = 16'h0020;
  localparam logic [ADDR_W-1:0] OFF_RESH  = 16'h0028;
  localparam logic [ADDR_W-1:0] OFF_RESL  = 16'h0030;

  typedef enum logic [3:0] {
    IDLE, CLR1, CLR0, INTEN, OPND, START, WAIT, RDH, RDL, ERR, RSP, FIN1, FIN0
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   operand;
  logic [CNT_W-1:0]    wait_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                cmd_ready_q;
  logic                m_sel_q;
  logic                m_wr_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_dout_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_h_q;
  logic [DATA_W-1:0]   rsp_l_q;
  logic                rsp_error_q;
  logic                done_c;
  logic                timeout_c;

  // Completion: interrupt level, or the OP_DONE read currently on the bus returning bit 0 set
  assign done_c    = USE_INTR ? bus.interrupt : (m_sel_q & ~m_wr_q & bus.m_din[0]);
  assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT - 1));

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.m_sel        = m_sel_q;
  assign bus.m_wr         = m_wr_q;
  assign bus.m_addr       = m_addr_q;
  assign bus.m_dout       = m_dout_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result_h = rsp_h_q;
  assign bus.rsp_result_l = rsp_l_q;
  assign bus.rsp_error    = rsp_error_q;

  // Sequencer; each transition sets up the bus transfer performed in the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      operand     <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      cmd_ready_q <= 1'b1;
      m_sel_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_dout_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_h_q     <= '0;
      rsp_l_q     <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      m_sel_q <= 1'b0;
      m_wr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            operand     <= bus.cmd_operand;
            cmd_ready_q <= 1'b0;
            state       <= CLR1;
            m_sel_q <= 1'b1; m_wr_q <= 1'b1;
            m_addr_q <= BASE_ADDR | OFF_CLEAR; m_dout_q <= DATA_W'(1);
          end
        end
        CLR1: begin
          state   <= CLR0;
          m_sel_q <= 1'b1; m_wr_q <= 1'b1;
          m_addr_q <= BASE_ADDR | OFF_CLEAR; m_dout_q <= '0;
        end
        CLR0: begin
          state   <= INTEN;
          m_sel_q <= 1'b1; m_wr_q <= 1'b1;
          m_addr_q <= BASE_ADDR | OFF_INTEN; m_dout_q <= DATA_W'(USE_INTR);
        end
        INTEN: begin
          state   <= OPND;
          m_sel_q <= 1'b1; m_wr_q <= 1'b1;
          m_addr_q <= BASE_ADDR | OFF_OPND; m_dout_q <= operand;
        end
        OPND: begin
          state   <= START;
          m_sel_q <= 1'b1; m_wr_q <= 1'b1;
          m_addr_q <= BASE_ADDR | OFF_START; m_dout_q <= DATA_W'(1);
        end
        START: begin
          state    <= WAIT;
          wait_cnt <= '0;
          gap_cnt  <= '0;
          if (!USE_INTR) begin
            m_sel_q  <= 1'b1;
            m_addr_q <= BASE_ADDR | OFF_DONE;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (done_c) begin
            state    <= RDH;
            m_sel_q  <= 1'b1;
            m_addr_q <= BASE_ADDR | OFF_RESH;
          end else if (timeout_c) begin
            state <= ERR;
          end else if (!USE_INTR) begin
            if (gap_cnt == GAP_W'(POLL_GAP)) begin
              gap_cnt  <= '0;
              m_sel_q  <= 1'b1;
              m_addr_q <= BASE_ADDR | OFF_DONE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        RDH: begin
          rsp_h_q  <= bus.m_din;
          state    <= RDL;
          m_sel_q  <= 1'b1;
          m_addr_q <= BASE_ADDR | OFF_RESL;
        end
        RDL: begin
          rsp_l_q     <= bus.m_din;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        ERR: begin
          rsp_h_q     <= '0;
          rsp_l_q     <= '0;
          rsp_error_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            state       <= FIN1;
            m_sel_q <= 1'b1; m_wr_q <= 1'b1;
            m_addr_q <= BASE_ADDR | OFF_CLEAR; m_dout_q <= DATA_W'(1);
          end
        end
        FIN1: begin
          state   <= FIN0;
          m_sel_q <= 1'b1; m_wr_q <= 1'b1;
          m_addr_q <= BASE_ADDR | OFF_CLEAR; m_dout_q <= '0;
        end
        FIN0: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
